cache_axi_wr_arb: RTL and testbench
===================================

Name: cache_axi_wr_arb

Overview:
- Two-master AXI3 write-channel arbiter, placed between the cache write-back engine (master 0) and the uncached/store-buffer write path (master 1).
- Both masters share the single L1 AXI write port toward the interconnect.
- One transaction is in flight at a time. A grant is held from the AW handshake through the W burst until the B handshake, then rotates round-robin.

Parameters:
- ID_W, 4, AXI ID width
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width
- LEN_W, 4, AxLEN width (AXI3)
- TIMEOUT_CYC, 1024, B-response watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- mN_awid/awaddr/awlen  in  ID_W/ADDR_W/LEN_W  master N (N=0,1) AW fields
- mN_awvalid  in  1 ; mN_awready  out  1
- mN_wid/wdata/wstrb/wlast  in  ID_W/DATA_W/DATA_W/8/1  master N W fields
- mN_wvalid  in  1 ; mN_wready  out  1
- mN_bid/bresp  out  ID_W/2 ; mN_bvalid  out  1 ; mN_bready  in  1
- s_awid/awaddr/awlen  out  ID_W/ADDR_W/LEN_W  shared port AW
- s_awvalid  out  1 ; s_awready  in  1
- s_wid/wdata/wstrb/wlast  out  ID_W/DATA_W/DATA_W/8/1 ; s_wvalid  out  1 ; s_wready  in  1
- s_bid/bresp  in  ID_W/2 ; s_bvalid  in  1 ; s_bready  out  1
- grant_o  out  2  one-hot current owner, 00 when idle
- err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; grant=00; priority pointer=master 0; aw_done=w_done=0; err_timeout=0.
  - All valid and ready outputs are 0.
  - Reset mid-burst abandons the transaction immediately. No partial B is forwarded.
- State IDLE:
  - Request is mN_awvalid.
  - Single request: grant it.
  - Both requesting: grant the master at the pointer.
  - The grant is registered. Go to XFER next cycle; s_awvalid can first be high 1 cycle after the request is seen.
- State XFER:
  - Muxes are combinational from the granted master. s_awvalid=m_awvalid&~aw_done, mG_awready=s_awready&~aw_done.
  - W path: s_wvalid=m_wvalid&~w_done, mG_wready=s_wready&~w_done.
  - W is allowed before, with, or after AW. This is pass-through; the arbiter does not count beats.
  - aw_done sets on the s_aw handshake. w_done sets on an s_w handshake with wlast=1.
  - When both are done (including the same cycle), go to RESP.
- State RESP:
  - s_bready=mG_bready. mG_bvalid=s_bvalid; bid/bresp pass through.
  - On the B handshake: clear grant, aw_done and w_done; pointer = other master; go to IDLE.
  - An s_bvalid seen outside RESP is not acknowledged (s_bready=0).
- Ungranted master: all ready outputs 0, bvalid 0, bid/bresp 0.
- Back-to-back: earliest re-grant is the cycle after the B handshake. This gives 1 idle cycle between transactions.
- bresp is forwarded unmodified, including SLVERR/DECERR. IDs are not remapped.

Optional Feature:
- Macro: CACHE_WR_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYC+1) clears on entry to RESP and increments each RESP cycle without s_bvalid.
  - At count==TIMEOUT_CYC, err_timeout sets (sticky until reset). The FSM keeps waiting; there is no forced release.
- Undefined: no counter; err_timeout is tied to 0.

Decomposition:
- cache_wb_def.v holds:
  - FSM state encodings (IDLE=2'd0, XFER=2'd1, RESP=2'd2)
  - BRESP codes
  - default AXI width macros, used for parameter defaults
  - RESET_ENABLE=1'b0 for this block
- Sub-module rr_arb2: 2-input round-robin grant. Inputs req[1:0], ptr, update; output one-hot gnt; registered pointer.
- FSM and muxes stay in the top.

Test Plan:
- Only m0 issues awaddr=0x1000, awlen=3, 4 beats, bresp=OKAY -> grant_o=01 one cycle after awvalid; 4 s_w beats with wlast on the 4th; m0_bvalid=1; m1 readies stay 0.
- m0 and m1 request in the same cycle after reset -> m0 granted first; after its B, m1 granted with exactly 1 idle cycle; a third m0 request after that goes to m0.
- m1 presents all W beats before AW (s_awready held 0 for 10 cycles) -> W passes through; RESP is entered only after the AW handshake; B is routed to m1.
- aw and last-w handshake in the same cycle, then s_bvalid with bresp=2'b10 -> RESP next cycle; m0_bresp=2'b10; grant released.
- reset pulled low mid-burst (beat 2 of 4) -> all valids and readies 0 in the same cycle; grant_o=00; after release, new requests are arbitrated from master 0.
- With CACHE_WR_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, s_bvalid withheld -> err_timeout rises after 16 RESP cycles and stays high after a later B; without the macro it stays 0.

Source files
------------

// File: rtl/cache_axi_wr_arb_pkg.sv
// rtl/cache_axi_wr_arb_pkg.sv - shared encodings and width defaults for the AXI3 write arbiter
package cache_axi_wr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam int DEF_ID_W   = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 4;

  // Level of the reset pin that means "in reset".
  localparam logic RESET_ENABLE = 1'b0;

endpackage

// File: rtl/cache_axi_wr_arb_rr_arb2.sv
// rtl/cache_axi_wr_arb_rr_arb2.sv - two-input round-robin grant with registered priority pointer
module rr_arb2
  import cache_axi_wr_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_from,
  output logic [1:0] gnt
);

  logic r_ptr;

  // After a master completes, the other master gets priority.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      r_ptr <= 1'b0;
    end else if (update) begin
      r_ptr <= ~upd_from;
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_axi_wr_arb.sv
// rtl/cache_axi_wr_arb.sv - two-master AXI3 write arbiter, one transaction in flight
// Optional B-response watchdog enabled by CACHE_WR_ARB_TIMEOUT_EN.
module cache_axi_wr_arb
  import cache_axi_wr_arb_pkg::*;
#(
  parameter int ID_W        = DEF_ID_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_W-1:0]     m0_awid,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [LEN_W-1:0]    m0_awlen,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [ID_W-1:0]     m0_wid,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wlast,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [ID_W-1:0]     m0_bid,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [LEN_W-1:0]    m1_awlen,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ID_W-1:0]     m1_wid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [ID_W-1:0]     m1_bid,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [ID_W-1:0]     s_awid,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [LEN_W-1:0]    s_awlen,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ID_W-1:0]     s_wid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [ID_W-1:0]     s_bid,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [1:0]          grant_o,
  output logic                err_timeout
);

  arb_state_e r_state, w_state_nx;
  logic [1:0] r_grant;
  logic       r_aw_done, r_w_done;
  logic [1:0] w_gnt;
  logic       w_in_xfer, w_in_resp;
  logic       w_awvalid, w_wvalid, w_wlast, w_bready;
  logic       w_aw_hs, w_wlast_hs, w_b_hs;

  rr_arb2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      ({m1_awvalid, m0_awvalid}),
    .update   (w_b_hs),
    .upd_from (r_grant[1]),
    .gnt      (w_gnt)
  );

  assign w_in_xfer = (r_state == ST_XFER);
  assign w_in_resp = (r_state == ST_RESP);
  assign grant_o   = r_grant;

  assign w_awvalid = r_grant[1] ? m1_awvalid : (r_grant[0] & m0_awvalid);
  assign w_wvalid  = r_grant[1] ? m1_wvalid  : (r_grant[0] & m0_wvalid);
  assign w_wlast   = r_grant[1] ? m1_wlast   : (r_grant[0] & m0_wlast);
  assign w_bready  = r_grant[1] ? m1_bready  : (r_grant[0] & m0_bready);

  assign s_awid   = r_grant[1] ? m1_awid   : (r_grant[0] ? m0_awid   : '0);
  assign s_awaddr = r_grant[1] ? m1_awaddr : (r_grant[0] ? m0_awaddr : '0);
  assign s_awlen  = r_grant[1] ? m1_awlen  : (r_grant[0] ? m0_awlen  : '0);
  assign s_wid    = r_grant[1] ? m1_wid    : (r_grant[0] ? m0_wid    : '0);
  assign s_wdata  = r_grant[1] ? m1_wdata  : (r_grant[0] ? m0_wdata  : '0);
  assign s_wstrb  = r_grant[1] ? m1_wstrb  : (r_grant[0] ? m0_wstrb  : '0);
  assign s_wlast  = w_wlast;

  // AW and W complete independently; each is masked once its own handshake is done.
  assign s_awvalid  = w_in_xfer & w_awvalid & ~r_aw_done;
  assign s_wvalid   = w_in_xfer & w_wvalid & ~r_w_done;
  assign s_bready   = w_in_resp & w_bready;
  assign w_aw_hs    = s_awvalid & s_awready;
  assign w_wlast_hs = s_wvalid & s_wready & w_wlast;
  assign w_b_hs     = s_bvalid & s_bready;

  assign m0_awready = r_grant[0] & w_in_xfer & s_awready & ~r_aw_done;
  assign m1_awready = r_grant[1] & w_in_xfer & s_awready & ~r_aw_done;
  assign m0_wready  = r_grant[0] & w_in_xfer & s_wready & ~r_w_done;
  assign m1_wready  = r_grant[1] & w_in_xfer & s_wready & ~r_w_done;
  assign m0_bvalid  = r_grant[0] & w_in_resp & s_bvalid;
  assign m1_bvalid  = r_grant[1] & w_in_resp & s_bvalid;
  assign m0_bid     = (r_grant[0] & w_in_resp) ? s_bid   : '0;
  assign m1_bid     = (r_grant[1] & w_in_resp) ? s_bid   : '0;
  assign m0_bresp   = (r_grant[0] & w_in_resp) ? s_bresp : 2'b00;
  assign m1_bresp   = (r_grant[1] & w_in_resp) ? s_bresp : 2'b00;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (|w_gnt) w_state_nx = ST_XFER;
      ST_XFER: if ((r_aw_done | w_aw_hs) && (r_w_done | w_wlast_hs)) w_state_nx = ST_RESP;
      ST_RESP: if (w_b_hs) w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      r_state   <= ST_IDLE;
      r_grant   <= 2'b00;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == ST_IDLE) begin
        r_grant <= w_gnt;
      end else if (w_b_hs) begin
        r_grant   <= 2'b00;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else if (w_in_xfer) begin
        if (w_aw_hs)    r_aw_done <= 1'b1;
        if (w_wlast_hs) r_w_done  <= 1'b1;
      end
    end
  end

`ifdef CACHE_WR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_err;

  // Counter saturates at the limit; the FSM keeps waiting for B regardless.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else if (w_in_xfer && (w_state_nx == ST_RESP)) begin
      r_to_cnt <= '0;
    end else if (w_in_resp && !s_bvalid && (r_to_cnt != CNT_W'(TIMEOUT_CYC))) begin
      r_to_cnt <= r_to_cnt + 1'b1;
      if (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1)) r_err <= 1'b1;
    end
  end

  assign err_timeout = r_err;
`else
  assign err_timeout = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_cache_axi_wr_arb.sv
// tb/tb_cache_axi_wr_arb.sv - self-checking bench for cache_axi_wr_arb
module tb_cache_axi_wr_arb;

  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4, SW = DATA_W / 8;

  logic clk = 1'b0;
  logic reset;
  logic [1:0][ID_W-1:0]   m_awid, m_wid, m_bid;
  logic [1:0][ADDR_W-1:0] m_awaddr;
  logic [1:0][LEN_W-1:0]  m_awlen;
  logic [1:0][DATA_W-1:0] m_wdata, wbase;
  logic [1:0][SW-1:0]     m_wstrb;
  logic [1:0][1:0]        m_bresp;
  logic [1:0] m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [ID_W-1:0]   s_awid, s_wid, s_bid;
  logic [ADDR_W-1:0] s_awaddr;
  logic [LEN_W-1:0]  s_awlen;
  logic [DATA_W-1:0] s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic [1:0]        s_bresp, grant_o;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready, err_timeout;

  int checks = 0, fails = 0;
  int mdl_ptr;
  logic [1:0] pend;

  always #5 clk = ~clk;

  cache_axi_wr_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset),
    .m0_awid(m_awid[0]), .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awvalid(m_awvalid[0]),
    .m0_awready(m_awready[0]), .m0_wid(m_wid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_wlast(m_wlast[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_bid(m_bid[0]),
    .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m1_awid(m_awid[1]), .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awvalid(m_awvalid[1]),
    .m1_awready(m_awready[1]), .m1_wid(m_wid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_wlast(m_wlast[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_bid(m_bid[1]),
    .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant_o(grant_o), .err_timeout(err_timeout)
  );

  task automatic clear_inputs;
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awvalid = '0; m_wid = '0; m_wdata = '0;
    m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
    s_awready = 0; s_wready = 0; s_bid = '0; s_bresp = '0; s_bvalid = 0;
  endtask

  task automatic do_reset;
    reset = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1;
    mdl_ptr = 0;
    pend = 2'b00;
  endtask

  task automatic req(input int m, input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
    m_awid[m] = ID_W'($urandom); m_wid[m] = m_awid[m];
    m_awaddr[m] = addr; m_awlen[m] = len; wbase[m] = $urandom;
    m_awvalid[m] = 1; m_wvalid[m] = 0; m_wlast[m] = 0;
    pend[m] = 1;
  endtask

  task automatic wait_grant(input logic [1:0] exp);
    @(negedge clk); #1;
    checks++;
    if (grant_o !== exp) begin fails++; $display("FAIL grant_latency1: got %b expected %b", grant_o, exp); end
  endtask

  // Drives master m and the slave side through one whole transaction, checking every cycle.
  task automatic serve(input int m, input logic [1:0] resp, input int hold_aw, input bit eager,
                       output int aw_cyc, output int wl_cyc, output int b_cyc);
    int o, beats, wi, cyc;
    bit aw_ok, b_ok, resp_ph;
    o = 1 - m; beats = int'(m_awlen[m]) + 1; wi = 0; cyc = 0;
    aw_ok = 0; b_ok = 0; aw_cyc = -1; wl_cyc = -1; b_cyc = -1;
    while (!b_ok && cyc < 300) begin
      if (cyc > 0) @(negedge clk);
      resp_ph = aw_ok && (wi == beats);
      m_awvalid[m] = !aw_ok;
      m_wvalid[m]  = (wi < beats);
      m_wdata[m]   = wbase[m] + 32'(wi);
      m_wstrb[m]   = SW'(wi + 1);
      m_wlast[m]   = (wi == beats - 1);
      if (eager) begin
        s_awready = 1; s_wready = 1; m_bready[m] = 1;
      end else if (cyc < hold_aw) begin
        s_awready = 0; s_wready = 1; m_bready[m] = 1'($urandom_range(0, 1));
      end else begin
        s_awready = ($urandom % 3) != 0; s_wready = ($urandom % 3) != 0; m_bready[m] = ($urandom % 3) != 0;
      end
      if (resp_ph) begin
        s_bvalid = eager ? 1'b1 : (($urandom % 3) != 0); s_bresp = resp; s_bid = m_awid[m];
      end else begin
        s_bvalid = ($urandom % 4) == 0; s_bresp = 2'($urandom); s_bid = ID_W'($urandom);
      end
      #1;
      checks++;
      if (grant_o !== 2'(1 << m)) begin fails++; $display("FAIL serve_grant: got %b expected %b", grant_o, 2'(1 << m)); end
      checks++;
      if ({m_awready[o], m_wready[o], m_bvalid[o], m_bid[o], m_bresp[o]} !== '0) begin
        fails++; $display("FAIL ungranted_quiet: m%0d awready=%b wready=%b bvalid=%b expected 0", o, m_awready[o], m_wready[o], m_bvalid[o]);
      end
      checks++;
      if (s_awvalid !== !aw_ok || m_awready[m] !== (s_awready & !aw_ok)) begin
        fails++; $display("FAIL aw_path: got valid=%b ready=%b expected valid=%b ready=%b", s_awvalid, m_awready[m], !aw_ok, s_awready & !aw_ok);
      end
      if (!aw_ok) begin
        checks++;
        if ({s_awid, s_awaddr, s_awlen} !== {m_awid[m], m_awaddr[m], m_awlen[m]}) begin
          fails++; $display("FAIL aw_fields: got addr=%h len=%0d expected addr=%h len=%0d", s_awaddr, s_awlen, m_awaddr[m], m_awlen[m]);
        end
      end
      checks++;
      if (s_wvalid !== (wi < beats) || m_wready[m] !== (s_wready & (wi < beats))) begin
        fails++; $display("FAIL w_path: got valid=%b ready=%b expected valid=%b", s_wvalid, m_wready[m], wi < beats);
      end
      if (wi < beats) begin
        checks++;
        if ({s_wid, s_wdata, s_wstrb, s_wlast} !== {m_wid[m], wbase[m] + 32'(wi), SW'(wi + 1), wi == beats - 1}) begin
          fails++; $display("FAIL w_beat%0d: got data=%h last=%b expected data=%h last=%b", wi, s_wdata, s_wlast, wbase[m] + 32'(wi), wi == beats - 1);
        end
      end
      checks++;
      if (resp_ph) begin
        if (s_bready !== m_bready[m] || m_bvalid[m] !== s_bvalid ||
            (s_bvalid && (m_bresp[m] !== resp || m_bid[m] !== m_awid[m]))) begin
          fails++; $display("FAIL b_path: got bready=%b bvalid=%b bresp=%b expected bready=%b bvalid=%b bresp=%b",
                            s_bready, m_bvalid[m], m_bresp[m], m_bready[m], s_bvalid, resp);
        end
      end else if (s_bready !== 1'b0 || m_bvalid[m] !== 1'b0) begin
        fails++; $display("FAIL b_outside_resp: got bready=%b bvalid=%b expected 0", s_bready, m_bvalid[m]);
      end
      if (s_awvalid && s_awready) begin aw_ok = 1; aw_cyc = cyc; end
      if (s_wvalid && s_wready) begin
        if (s_wlast) wl_cyc = cyc;
        wi++;
      end
      if (s_bvalid && s_bready) begin b_ok = 1; b_cyc = cyc; end
      cyc++;
    end
    checks++;
    if (!b_ok) begin fails++; $display("FAIL serve_bound: transaction of m%0d did not finish, got %0d cycles expected < 300", m, cyc); end
    @(negedge clk);
    s_bvalid = 0; m_bready[m] = 0; s_awready = 0; s_wready = 0;
    #1;
    checks++;
    if (grant_o !== 2'b00 || s_awvalid !== 1'b0) begin
      fails++; $display("FAIL idle_gap: got grant=%b awvalid=%b expected 00/0", grant_o, s_awvalid);
    end
    pend[m] = 0;
    mdl_ptr = o;
  endtask

  task automatic test_reset;
    int a, w, b;
    reset = 0;
    clear_inputs();
    m_awvalid = 2'b11; m_wvalid = 2'b11; m_bready = 2'b11;
    s_awready = 1; s_wready = 1; s_bvalid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid, grant_o, err_timeout} !== '0) begin
        fails++; $display("FAIL reset_outputs: got awv=%b wv=%b br=%b grant=%b err=%b expected all 0", s_awvalid, s_wvalid, s_bready, grant_o, err_timeout);
      end
    end
    do_reset();
    a = 0; w = 0; b = 0;
  endtask

  task automatic test_single_m0;
    int a, w, b;
    do_reset();
    req(0, 4'd3, 32'h1000);
    #1;
    checks++;
    if (grant_o !== 2'b00 || s_awvalid !== 1'b0) begin
      fails++; $display("FAIL single_pre_grant: got grant=%b awvalid=%b expected 00/0", grant_o, s_awvalid);
    end
    wait_grant(2'b01);
    serve(0, 2'b00, 0, 0, a, w, b);
  endtask

  task automatic test_simultaneous;
    int a, w, b;
    do_reset();
    req(0, 4'($urandom_range(0, 5)), $urandom);
    req(1, 4'($urandom_range(0, 5)), $urandom);
    wait_grant(2'b01);
    serve(0, 2'b00, 0, 0, a, w, b);
    wait_grant(2'b10);
    serve(1, 2'b01, 0, 0, a, w, b);
    req(0, 4'd1, $urandom);
    wait_grant(2'b01);
    serve(0, 2'b00, 0, 0, a, w, b);
  endtask

  task automatic test_w_before_aw;
    int a, w, b;
    req(1, 4'd3, $urandom);
    wait_grant(2'b10);
    serve(1, 2'b00, 10, 0, a, w, b);
    checks++;
    if (!(w >= 0 && a >= 10 && w < a && b > a)) begin
      fails++; $display("FAIL w_before_aw_order: got wlast@%0d aw@%0d b@%0d expected wlast < aw (aw >= 10) < b", w, a, b);
    end
  endtask

  task automatic test_same_cycle;
    int a, w, b;
    req(0, 4'd0, $urandom);
    wait_grant(2'b01);
    serve(0, 2'b10, 0, 1, a, w, b);
    checks++;
    if (a != 0 || w != 0 || b != 1) begin
      fails++; $display("FAIL same_cycle_resp: got aw@%0d wlast@%0d b@%0d expected 0/0/1", a, w, b);
    end
  endtask

  task automatic test_random;
    int a, w, b, exp;
    for (int r = 0; r < 14 || pend != 2'b00; r++) begin
      if (r < 14) begin
        for (int m = 0; m < 2; m++)
          if (!pend[m] && ($urandom % 2) == 1) req(m, 4'($urandom_range(0, 7)), $urandom);
        if (pend == 2'b00) req(int'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom);
      end
      exp = (pend == 2'b11) ? mdl_ptr : (pend[0] ? 0 : 1);
      wait_grant(2'(1 << exp));
      serve(exp, 2'($urandom), 0, 0, a, w, b);
    end
  endtask

  task automatic test_reset_mid_burst;
    int a, w, b;
    req(0, 4'd0, $urandom);
    wait_grant(2'b01);
    serve(0, 2'b00, 0, 0, a, w, b);
    req(1, 4'd3, $urandom);
    wait_grant(2'b10);
    s_awready = 1; s_wready = 1;
    m_wvalid[1] = 1; m_wdata[1] = wbase[1]; m_wlast[1] = 0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      m_awvalid[1] = 0; m_wdata[1] = wbase[1] + 32'(i);
    end
    s_bvalid = 1; m_bready = 2'b11;
    reset = 0;
    #1;
    checks++;
    if ({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid, grant_o} !== '0) begin
      fails++; $display("FAIL reset_mid_burst: got wv=%b wr=%b bv=%b grant=%b expected all 0", s_wvalid, m_wready, m_bvalid, grant_o);
    end
    @(negedge clk);
    clear_inputs();
    pend = 2'b00; mdl_ptr = 0;
    reset = 1;
    req(0, 4'd1, $urandom);
    req(1, 4'd1, $urandom);
    wait_grant(2'b01);
    serve(0, 2'b00, 0, 0, a, w, b);
    wait_grant(2'b10);
    serve(1, 2'b00, 0, 0, a, w, b);
  endtask

  task automatic test_timeout;
    logic exp_err;
`ifdef CACHE_WR_ARB_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    req(0, 4'd0, $urandom);
    m_wvalid[0] = 1; m_wlast[0] = 1; m_wdata[0] = wbase[0];
    s_awready = 1; s_wready = 1; s_bvalid = 0;
    wait_grant(2'b01);
    @(negedge clk);
    m_awvalid[0] = 0; m_wvalid[0] = 0; s_awready = 0; s_wready = 0;
    #1;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      if (k == 16) begin
        checks++;
        if (err_timeout !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b expected 0 after 15 RESP cycles", err_timeout); end
      end
      if (k == 17) begin
        checks++;
        if (err_timeout !== exp_err) begin fails++; $display("FAIL timeout_rise: got %b expected %b after 16 RESP cycles", err_timeout, exp_err); end
      end
    end
    s_bvalid = 1; s_bresp = 2'b00; m_bready[0] = 1;
    @(negedge clk);
    s_bvalid = 0; m_bready[0] = 0;
    #1;
    checks++;
    if (grant_o !== 2'b00 || err_timeout !== exp_err) begin
      fails++; $display("FAIL timeout_sticky: got grant=%b err=%b expected 00/%b", grant_o, err_timeout, exp_err);
    end
    pend = 2'b00;
    do_reset();
    #1;
    checks++;
    if (err_timeout !== 1'b0) begin fails++; $display("FAIL timeout_reset_clear: got %b expected 0", err_timeout); end
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    mdl_ptr = 0;
    pend = 2'b00;
    test_reset();
    test_single_m0();
    test_simultaneous();
    test_w_before_aw();
    test_same_cycle();
    test_random();
    test_reset_mid_burst();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_watchdog: simulation still running at %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
